eigen_bank_pp: RTL

Parametrised ping-pong store for the PCA eigenvector matrix used by the face-recognition projection datapath. The host streams coefficients into a shadow bank over a valid/ready interface, with an internal auto-incrementing pixel/eigen address. The projection engine reads all eigen columns for one pixel per request from the active bank. A swap command exchanges the banks, so a new eigenface set loads while compute continues.

---
 rtl/eigen_bank_pp.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/eigen_bank_pp.sv
// rtl/eigen_bank_pp.sv - ping-pong eigenvector coefficient store with streamed shadow load
//
// Two banks of NUM_EIGEN x NUM_PIXELS coefficients. The host streams a new
// eigenface set into the shadow bank while the projection engine reads whole
// pixel rows (all eigen columns at once) from the active bank.
//
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   clear             synchronous wipe of both banks, load state and err
//   load_start        restart shadow load at pixel 0, eigen 0
//   wr_valid/wr_data  coefficient beat; accepted when wr_valid && wr_ready
//   wr_ready          high while a load is in progress
//   load_full         shadow bank completely loaded
//   load_done         one-cycle pulse after the final accepted beat
//   swap              exchange active and shadow banks (legal only when full)
//   active_bank       bank currently serving reads
//   rd_en/rd_pixel    read request for one pixel row
//   rd_valid/rd_data  registered read response, column e at [e*DATA_W +: DATA_W]
//   err               sticky: illegal swap or out-of-range read
module eigen_bank_pp #(
    parameter int NUM_PIXELS = 161,
    parameter int NUM_EIGEN  = 8,
    parameter int DATA_W     = 32,
    parameter int PIX_W      = 16,
    parameter int EIG_W      = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          clear,
    input  logic                          load_start,
    input  logic                          wr_valid,
    input  logic [DATA_W-1:0]             wr_data,
    output logic                          wr_ready,
    output logic                          load_full,
    output logic                          load_done,
    input  logic                          swap,
    output logic                          active_bank,
    input  logic                          rd_en,
    input  logic [PIX_W-1:0]              rd_pixel,
    output logic                          rd_valid,
    output logic [NUM_EIGEN*DATA_W-1:0]   rd_data,
    output logic                          err
);

    // Array index widths; counters keep their full PIX_W/EIG_W width.
    localparam int PA = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1;
    localparam int EA = (NUM_EIGEN  > 1) ? $clog2(NUM_EIGEN)  : 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LOADING = 2'd1,
        ST_FULL    = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [PIX_W-1:0]  pix_cnt;
    logic [EIG_W-1:0]  eig_cnt;
    logic [DATA_W-1:0] mem [2][NUM_EIGEN][NUM_PIXELS];

    logic                        beat_acc;
    logic                        last_pix;
    logic                        last_beat;
    logic                        swap_ok;
    logic                        shadow;
    logic                        rd_oor;
    logic [NUM_EIGEN*DATA_W-1:0] rd_word;

    // A beat coincident with clear or load_start is discarded.
    assign beat_acc  = wr_valid && wr_ready && !clear && !load_start;
    assign last_pix  = (pix_cnt == PIX_W'(NUM_PIXELS - 1));
    assign last_beat = last_pix && (eig_cnt == EIG_W'(NUM_EIGEN - 1));
    assign swap_ok   = swap && (state == ST_FULL);
    assign shadow    = ~active_bank;
    assign rd_oor    = (rd_pixel >= PIX_W'(NUM_PIXELS));

    // ---------------- load FSM: state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ---------------- load FSM: next state ----------------
    // load_start outranks swap for the next state so that swap+load_start in
    // FULL lands in LOADING with the bank toggle still applied.
    always_comb begin
        state_nxt = state;
        if (clear) begin
            state_nxt = ST_IDLE;
        end else if (load_start) begin
            state_nxt = ST_LOADING;
        end else if (swap_ok) begin
            state_nxt = ST_IDLE;
        end else if (beat_acc && last_beat) begin
            state_nxt = ST_FULL;
        end
    end

    // ---------------- load FSM: outputs ----------------
    always_comb begin
        wr_ready  = 1'b0;
        load_full = 1'b0;
        case (state)
            ST_LOADING: wr_ready  = 1'b1;
            ST_FULL:    load_full = 1'b1;
            default:    ;
        endcase
    end

    // ---------------- load address counters ----------------
    // Pixel-major within an eigen column.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_cnt <= '0;
            eig_cnt <= '0;
        end else if (clear || load_start) begin
            pix_cnt <= '0;
            eig_cnt <= '0;
        end else if (beat_acc) begin
            if (last_pix) begin
                pix_cnt <= '0;
                eig_cnt <= eig_cnt + 1'b1;
            end else begin
                pix_cnt <= pix_cnt + 1'b1;
            end
        end
    end

    // ---------------- load_done pulse ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            load_done <= 1'b0;
        end else if (clear) begin
            load_done <= 1'b0;
        end else begin
            load_done <= beat_acc && last_beat;
        end
    end

    // ---------------- bank select ----------------
    // clear leaves the selected bank alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_bank <= 1'b0;
        end else if (!clear && swap_ok) begin
            active_bank <= ~active_bank;
        end
    end

    // ---------------- sticky error ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else if (clear) begin
            err <= 1'b0;
        end else if ((swap && (state != ST_FULL)) || (rd_en && rd_oor)) begin
            err <= 1'b1;
        end
    end

    // ---------------- coefficient storage ----------------
    // Writes only ever hit the shadow bank, so reads of the active bank in the
    // same cycle never see a partially written row.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int b = 0; b < 2; b++) begin
                for (int e = 0; e < NUM_EIGEN; e++) begin
                    for (int p = 0; p < NUM_PIXELS; p++) begin
                        mem[b][e][p] <= '0;
                    end
                end
            end
        end else if (clear) begin
            for (int b = 0; b < 2; b++) begin
                for (int e = 0; e < NUM_EIGEN; e++) begin
                    for (int p = 0; p < NUM_PIXELS; p++) begin
                        mem[b][e][p] <= '0;
                    end
                end
            end
        end else if (beat_acc) begin
            mem[shadow][eig_cnt[EA-1:0]][pix_cnt[PA-1:0]] <= wr_data;
        end
    end

    // ---------------- read path ----------------
    // Gather all eigen columns of the requested pixel from the active bank as
    // it stands before any swap in this cycle.
    always_comb begin
        rd_word = '0;
        for (int e = 0; e < NUM_EIGEN; e++) begin
            rd_word[e*DATA_W +: DATA_W] = mem[active_bank][EA'(e)][rd_pixel[PA-1:0]];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else if (clear) begin
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) begin
                rd_data <= rd_oor ? '0 : rd_word;
            end
        end
    end

endmodule
